// File: rtl/line_window_buf_pkg.sv
// lwb_pkg -- shared definitions for the 3x3 line-window buffer.
//   PIX_W_DEF : default pixel width in bits
//   WIN_N     : number of pixels in one window (3x3)
//   pix_t     : pixel type at the default width
//   win_lsb() : LSB position of window pixel k (1..9) inside the packed window
package lwb_pkg;

  localparam int PIX_W_DEF = 16;
  localparam int WIN_N     = 9;

  typedef logic [PIX_W_DEF-1:0] pix_t;

  // Pixel k occupies bits [k*pix_w-1 -: pix_w], so its LSB sits at (k-1)*pix_w.
  function automatic int win_lsb(input int k, input int pix_w);
    return (k - 1) * pix_w;
  endfunction

endpackage

// File: rtl/line_window_buf_line_ram.sv
// line_ram -- one image line of pixel storage.
//   clk   : clock
//   we    : write enable (write lands on the rising edge)
//   addr  : shared read/write column address
//   wdata : pixel to store at addr
//   rdata : combinational read of addr (returns the old value during a write)
module line_ram #(
  parameter int DEPTH = 320,
  parameter int WIDTH = 16,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/line_window_buf.sv
// line_window_buf -- turns a raster pixel stream into 3x3 windows.
//   clk       : clock
//   reset_n   : asynchronous active-low reset
//   in_valid  : in_pixel / in_sof valid
//   in_ready  : a pixel is accepted this cycle when in_valid is also high
//   in_pixel  : raster-order pixel
//   in_sof    : first pixel of a frame (restarts column/row at 0,0)
//   out_valid : out_win holds a complete window
//   out_ready : downstream takes the window
//   out_win   : pixel k (1..9, raster order) in bits [k*PIX_W-1 -: PIX_W]
//   win_count : (only with LINE_WINDOW_BUF_WINCNT_EN defined) count of
//               delivered windows, cleared by reset and by an accepted in_sof
module line_window_buf
  import lwb_pkg::*;
#(
  parameter int IMG_W = 320,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIX_W-1:0]       in_pixel,
  input  logic                   in_sof,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIN_N*PIX_W-1:0] out_win
`ifdef LINE_WINDOW_BUF_WINCNT_EN
  ,
  output logic [15:0]            win_count
`endif
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic [CW-1:0]    col_reg, col_next, cur_col;
  logic [1:0]       row_reg, row_next, cur_row;
  logic             out_valid_reg, out_valid_next;
  logic             accept;
  logic             win_hit;
  logic [PIX_W-1:0] line_r1_rd, line_r2_rd;
  logic [PIX_W-1:0] col_in [3];

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  // An in_sof pixel is position (0,0) no matter where the counters stood.
  assign cur_col = in_sof ? '0 : col_reg;
  assign cur_row = in_sof ? 2'd0 : row_reg;
  assign win_hit = (cur_row == 2'd2) && (cur_col >= CW'(2));

  always_comb begin
    col_next       = col_reg;
    row_next       = row_reg;
    out_valid_next = out_valid_reg;
    if (accept) begin
      // Acceptance implies the old window is being taken (or absent),
      // so the new state depends only on this pixel.
      out_valid_next = win_hit;
      if (cur_col == CW'(IMG_W - 1)) begin
        col_next = '0;
        row_next = (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
      end else begin
        col_next = cur_col + CW'(1);
        row_next = cur_row;
      end
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_reg       <= '0;
      row_reg       <= 2'd0;
      out_valid_reg <= 1'b0;
    end else begin
      col_reg       <= col_next;
      row_reg       <= row_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign out_valid = out_valid_reg;

  // Row r-1 takes the incoming pixel; row r-2 takes what row r-1 held.
  line_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_line_r1 (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_col),
    .wdata (in_pixel),
    .rdata (line_r1_rd)
  );

  line_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_line_r2 (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_col),
    .wdata (line_r1_rd),
    .rdata (line_r2_rd)
  );

  assign col_in[0] = line_r2_rd;
  assign col_in[1] = line_r1_rd;
  assign col_in[2] = in_pixel;

  // Window rows: each shifts left by one column per accepted pixel. The
  // window only moves on acceptance, so it is stable while stalled and can
  // drive out_win directly.
  for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
    logic [PIX_W-1:0] tap_reg [3];

    always_ff @(posedge clk) begin
      if (accept) begin
        tap_reg[0] <= tap_reg[1];
        tap_reg[1] <= tap_reg[2];
        tap_reg[2] <= col_in[gi];
      end
    end

    for (genvar gj = 0; gj < 3; gj++) begin : g_tap
      localparam int LSB = win_lsb(gi * 3 + gj + 1, PIX_W);
      assign out_win[LSB +: PIX_W] = tap_reg[gj];
    end
  end

`ifdef LINE_WINDOW_BUF_WINCNT_EN
  // A new frame restarts the count; a handshake on the final window of
  // the previous frame in the same cycle belongs to the old frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_count <= 16'd0;
    end else if (accept && in_sof) begin
      win_count <= 16'd0;
    end else if (out_valid_reg && out_ready) begin
      win_count <= win_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/line_window_buf.md
LINE_WINDOW_BUF -- requirements
Module: line_window_buf

Interface
REQ-001 Parameter IMG_W, default 320, SHALL set pixels per image line (legal range 3..1024).
REQ-002 Parameter PIX_W, default 16, SHALL set the pixel width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL indicate that in_pixel and in_sof are valid.
REQ-006 in_ready  output  1  SHALL indicate that the block accepts a pixel this cycle.
REQ-007 in_pixel  input  PIX_W  SHALL carry the raster-order pixel.
REQ-008 in_sof  input  1  SHALL mark the first pixel of a frame; it is qualified by in_valid.
REQ-009 out_valid  output  1  SHALL indicate that out_win holds a complete 3x3 window.
REQ-010 out_ready  input  1  SHALL indicate that the downstream edge-detect loader takes the window.
REQ-011 out_win  output  9*PIX_W  SHALL carry pixel k (k=1..9) in bits [k*PIX_W-1 -: PIX_W].
- Order is raster: p1 = top-left, p5 = centre, p9 = bottom-right.

Function
REQ-012 A pixel SHALL be accepted when in_valid && in_ready.
REQ-013 in_ready SHALL equal !out_valid || out_ready (single output register, no combinational path from in_valid).
REQ-014 A column counter (0..IMG_W-1) SHALL advance per accepted pixel and wrap to 0 after IMG_W-1.
- On wrap, a row flag SHALL advance 0 -> 1 -> 2 and saturate at 2.
REQ-015 Two line buffers of IMG_W x PIX_W SHALL hold rows r-1 and r-2.
- On acceptance at column c: row-(r-2) entry c <= row-(r-1) entry c, and row-(r-1) entry c <= in_pixel.
REQ-016 A 3x3 shift register SHALL shift one column left per accepted pixel.
- New right column = {line r-2 [c], line r-1 [c], in_pixel}.
REQ-017 Acceptance of pixel (r,c) with r>=2 and c>=2 SHALL set out_valid on the next edge.
- out_win is the window centred on (r-1,c-1); latency is 1 cycle.
REQ-018 Pixels with r<2 or c<2 SHALL update storage but SHALL NOT produce a window.
REQ-019 While out_valid && !out_ready, out_win SHALL hold stable and no pixel SHALL be accepted.
REQ-020 out_valid SHALL clear on out_ready when no new window is produced in that same cycle.
- A simultaneous out_ready and new window SHALL replace the window with no bubble.
REQ-021 An accepted in_sof pixel SHALL be treated as (0,0).
- Column and row restart from 0 and no window is produced from it.
- Line-buffer contents need not be cleared.
- An in_sof mid-line SHALL restart the frame immediately.
- A pending out_valid window SHALL still be delivered.
REQ-022 in_sof without in_valid SHALL be ignored.

Reset
REQ-023 Reset SHALL force out_valid=0, column=0, row=0, and in_ready=1 after release.
- out_win, the shift register and the line buffers are don't-care.
REQ-024 Reset asserted mid-frame SHALL abandon the frame; the next accepted pixel is (0,0) regardless of in_sof.

Configuration
REQ-025 Macro LINE_WINDOW_BUF_WINCNT_EN, when defined, SHALL add output win_count[15:0].
- Increments per window handshake (out_valid && out_ready) and wraps at 65535 -> 0.
- Cleared by reset and by an accepted in_sof.
- When undefined, the port and counter SHALL not exist.

Structure
REQ-026 Package lwb_pkg SHALL hold PIX_W default, WIN_N=9, typedef pix_t, and the window-slice index function.
REQ-027 The line buffers SHALL be one sub-module line_ram (IMG_W x PIX_W, one write port, one combinational read port), instantiated twice.

Verification (IMG_W=4, out_ready=1 unless stated)
REQ-028 4x4 frame, values 0..15 with in_sof on 0 -> exactly 4 windows.
- First window p1..p9 = 0,1,2,4,5,6,8,9,10; last window centre = 10.
REQ-029 Same frame, out_ready low for 5 cycles after the first window -> in_ready low and out_win constant for 5 cycles.
- All 4 windows are delivered in order with none lost or duplicated.
REQ-030 in_sof reasserted at pixel 6, then a fresh 4x4 frame 100..115 -> no window until new (2,2).
- First new window p5 = 105.
REQ-031 reset_n pulsed low after pixel 9 -> out_valid=0 immediately.
- A following 4x4 frame without in_sof yields 4 correct windows.
REQ-032 With LINE_WINDOW_BUF_WINCNT_EN, two full frames -> win_count=4 after frame 1.
- win_count resets to 0 on the second frame's in_sof and equals 4 at the end.
